// File: rtl/iobus_timer_pkg.sv
// Shared definitions for the I/O-bus down-counting timer: register word
// offsets, CTRL bit positions and the control state encoding.
package iobus_timer_pkg;

  localparam int PS_W_DEF = 4;

  // Word offsets within the register window (IOBUS_ADDR[3:2])
  localparam logic [1:0] OFS_CTRL  = 2'd0;
  localparam logic [1:0] OFS_LOAD  = 2'd1;
  localparam logic [1:0] OFS_COUNT = 2'd2;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_PS_LSB = 2;
  localparam int CTRL_IRQ    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iobus_timer_prescaler.sv
// Power-of-two prescaler: ticks once every 2^ps enabled cycles. A ps shrunk
// below the running count lets the counter wrap naturally before ticking.
module iobus_timer_prescaler
  import iobus_timer_pkg::*;
#(
  parameter int PS_W = PS_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            clear,
  input  logic [PS_W-1:0] ps,
  output logic            tick
);

  localparam int CW = (1 << PS_W) - 1;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] limit;

  // limit = 2^ps - 1, built as a mask so ps = 2^PS_W - 1 yields all ones
  assign limit = ~({CW{1'b1}} << ps);
  assign tick  = enable && (cnt_reg == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/iobus_timer.sv
// Memory-mapped down-counting timer with one-shot/periodic modes and prescaler.
// Define IOBUS_TIMER_LEVEL_IRQ_EN to drive intr from the IRQ flag (level).
module iobus_timer
  import iobus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_D000,
  parameter int          PS_W      = PS_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic        intr
);

  state_t          state_reg, state_next;
  logic            en_reg, en_next;
  logic            auto_reg, auto_next;
  logic [PS_W-1:0] ps_reg, ps_next;
  logic            irq_reg, irq_next;
  logic [31:0]     load_reg, load_next;
  logic [31:0]     count_reg, count_next;
  logic            presc_clear;
  logic            tick;
  logic            expire;
  logic [1:0]      word;
  logic            hit;
  logic            wr_ctrl;
  logic            wr_load;
  logic [31:0]     ctrl_rd;
  logic            unused_addr_bits;

  assign word             = iobus_addr[3:2];
  assign hit              = (iobus_addr[31:4] == BASE_ADDR[31:4]) && (word != 2'b11);
  assign wr_ctrl          = iobus_wr && hit && (word == OFS_CTRL);
  assign wr_load          = iobus_wr && hit && (word == OFS_LOAD);
  assign unused_addr_bits = &{1'b0, iobus_addr[1:0]};

  iobus_timer_prescaler #(.PS_W(PS_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_reg == RUN),
    .clear  (presc_clear),
    .ps     (ps_reg),
    .tick   (tick)
  );

  always_comb begin
    state_next  = state_reg;
    en_next     = en_reg;
    auto_next   = auto_reg;
    ps_next     = ps_reg;
    irq_next    = irq_reg;
    count_next  = count_reg;
    presc_clear = 1'b0;
    expire      = 1'b0;
    load_next   = wr_load ? iobus_out : load_reg;

    if (wr_ctrl) begin
      en_next   = iobus_out[CTRL_EN];
      auto_next = iobus_out[CTRL_AUTO];
      ps_next   = iobus_out[CTRL_PS_LSB +: PS_W];
      if (iobus_out[CTRL_IRQ]) irq_next = 1'b0;
    end

    case (state_reg)
      RUN: begin
        if (wr_ctrl && !iobus_out[CTRL_EN]) begin
          state_next = IDLE;
        end else if (tick) begin
          if (count_reg != 32'd0) begin
            count_next = count_reg - 32'd1;
          end else begin
            // Expiry: the set overrides any same-cycle W1C above
            expire   = 1'b1;
            irq_next = 1'b1;
            if (auto_next) begin
              count_next = load_next;
            end else begin
              en_next    = 1'b0;
              state_next = DONE;
            end
          end
        end
      end
      default: begin
        if (wr_ctrl && iobus_out[CTRL_EN]) begin
          count_next  = load_next;
          presc_clear = 1'b1;
          state_next  = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      en_reg    <= 1'b0;
      auto_reg  <= 1'b0;
      ps_reg    <= '0;
      irq_reg   <= 1'b0;
      load_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      en_reg    <= en_next;
      auto_reg  <= auto_next;
      ps_reg    <= ps_next;
      irq_reg   <= irq_next;
      load_reg  <= load_next;
      count_reg <= count_next;
    end
  end

`ifdef IOBUS_TIMER_LEVEL_IRQ_EN
  logic unused_expire;
  assign unused_expire = expire;
  assign intr          = irq_reg;
`else
  logic intr_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) intr_reg <= 1'b0;
    else        intr_reg <= expire;
  end
  assign intr = intr_reg;
`endif

  always_comb begin
    ctrl_rd                            = '0;
    ctrl_rd[CTRL_EN]                   = en_reg;
    ctrl_rd[CTRL_AUTO]                 = auto_reg;
    ctrl_rd[CTRL_PS_LSB +: PS_W]       = ps_reg;
    ctrl_rd[CTRL_IRQ]                  = irq_reg;
  end

  assign rd_hit = hit;

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (word)
        OFS_CTRL:  rd_data = ctrl_rd;
        OFS_LOAD:  rd_data = load_reg;
        OFS_COUNT: rd_data = count_reg;
        default:   rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_timer.sv
// Directed bench for iobus_timer (default pulse-interrupt build): a vector
// table of bus cycles plus hand-written periodic, W1C-race and reset sequences.
module tb_iobus_timer;

  localparam logic [31:0] A_CTRL  = 32'h1100_D000;
  localparam logic [31:0] A_LOAD  = 32'h1100_D004;
  localparam logic [31:0] A_COUNT = 32'h1100_D008;
  localparam logic [31:0] A_GAP   = 32'h1100_D00C;
  localparam logic [31:0] A_OUT   = 32'h1100_D010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iobus_wr = 1'b0;
  logic [31:0] iobus_addr = '0;
  logic [31:0] iobus_out = '0;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic        intr;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_data;
    logic        exp_intr;
  } vec_t;

  vec_t vecs[$];

  iobus_timer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iobus_addr (iobus_addr),
    .iobus_out  (iobus_out),
    .iobus_wr   (iobus_wr),
    .rd_data    (rd_data),
    .rd_hit     (rd_hit),
    .intr       (intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic exp_hit, input logic [31:0] exp_data, input logic exp_intr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_hit = exp_hit; v.exp_data = exp_data; v.exp_intr = exp_intr;
    vecs.push_back(v);
  endfunction

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    @(negedge clk);
    iobus_wr   = 1'b0;
  endtask

  initial begin
    logic exp_pulse;

    // Reset
    repeat (3) @(negedge clk);
    iobus_addr = A_COUNT;
    #1;
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_count", rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Each row: inputs held for one cycle; reads show state before that cycle's edge
    add(0, A_COUNT, 0,      1, 32'h0,   0);
    add(0, A_GAP,   0,      0, 32'h0,   0);
    add(0, A_OUT,   0,      0, 32'h0,   0);
    add(0, A_CTRL,  0,      1, 32'h0,   0);
    add(1, A_LOAD,  3,      1, 32'h0,   0);
    add(1, A_CTRL,  32'h1,  1, 32'h0,   0);   // enable edge: COUNT <= 3
    add(0, A_COUNT, 0,      1, 32'd3,   0);
    add(0, A_COUNT, 0,      1, 32'd2,   0);
    add(0, A_COUNT, 0,      1, 32'd1,   0);
    add(0, A_COUNT, 0,      1, 32'd0,   0);   // 4th edge after enable: expiry
    add(0, A_CTRL,  0,      1, 32'h100, 1);
    add(0, A_COUNT, 0,      1, 32'd0,   0);
    add(1, A_CTRL,  32'h100,1, 32'h100, 0);   // W1C
    add(0, A_CTRL,  0,      1, 32'h0,   0);
    add(1, A_LOAD,  9,      1, 32'd3,   0);
    add(1, A_CTRL,  32'h1,  1, 32'h0,   0);
    add(0, A_COUNT, 0,      1, 32'd9,   0);
    add(0, A_COUNT, 0,      1, 32'd8,   0);
    add(0, A_COUNT, 0,      1, 32'd7,   0);
    add(0, A_COUNT, 0,      1, 32'd6,   0);
    add(1, A_CTRL,  32'h0,  1, 32'h1,   0);   // disable with COUNT = 5
    add(0, A_COUNT, 0,      1, 32'd5,   0);
    add(0, A_COUNT, 0,      1, 32'd5,   0);
    add(0, A_CTRL,  0,      1, 32'h0,   0);
    add(1, A_LOAD,  2,      1, 32'd9,   0);
    add(1, A_CTRL,  32'h1,  1, 32'h0,   0);   // restart: COUNT <= 2
    add(0, A_COUNT, 0,      1, 32'd2,   0);
    add(0, A_COUNT, 0,      1, 32'd1,   0);
    add(0, A_COUNT, 0,      1, 32'd0,   0);
    add(0, A_CTRL,  0,      1, 32'h100, 1);
    add(1, A_COUNT, 32'h55, 1, 32'd0,   0);   // COUNT is read-only
    add(0, A_COUNT, 0,      1, 32'd0,   0);
    add(0, A_LOAD + 32'd1, 0, 1, 32'd2, 0);   // byte offset bits ignored
    add(1, A_CTRL,  32'h100,1, 32'h100, 0);
    add(0, A_CTRL,  0,      1, 32'h0,   0);

    for (int i = 0; i < vecs.size(); i++) begin
      iobus_wr   = vecs[i].wr;
      iobus_addr = vecs[i].addr;
      iobus_out  = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_hit", i), 32'(rd_hit), 32'(vecs[i].exp_hit));
      check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
      check($sformatf("vec%0d_intr", i), 32'(intr), 32'(vecs[i].exp_intr));
      @(negedge clk);
    end
    iobus_wr = 1'b0;

    // Periodic, PS = 2, LOAD = 1: pulse every 8 cycles; LOAD = 3 written mid-run
    bus_write(A_LOAD, 32'd1);
    bus_write(A_CTRL, 32'h0B);
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      #1;
      exp_pulse = ((k % 8 == 0) && (k <= 40)) || (k == 56) || (k == 72);
      check($sformatf("periodic_intr_k%0d", k), 32'(intr), 32'(exp_pulse));
      iobus_wr = (k == 33);
      if (k == 33) begin
        iobus_addr = A_LOAD;
        iobus_out  = 32'd3;
      end
    end
    iobus_wr = 1'b0;
    bus_write(A_CTRL, 32'h0);

    // W1C racing an expiry every cycle: set wins
    bus_write(A_LOAD, 32'd0);
    bus_write(A_CTRL, 32'h3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("every_cycle_intr_%0d", k), 32'(intr), 32'd1);
    end
    bus_write(A_CTRL, 32'h103);
    iobus_addr = A_CTRL;
    #1;
    check("w1c_race_ctrl", rd_data, 32'h103);
    bus_write(A_CTRL, 32'h100);
    iobus_addr = A_CTRL;
    #1;
    check("w1c_stop_ctrl", rd_data, 32'h0);
    check("w1c_stop_intr", 32'(intr), 32'd0);

    // Asynchronous reset while an interrupt pulse is out
    bus_write(A_LOAD, 32'd2);
    bus_write(A_CTRL, 32'h1);
    @(negedge clk);
    iobus_addr = A_COUNT;
    #1;
    check("arst_pre_count", rd_data, 32'd1);
    @(negedge clk);
    @(negedge clk);
    iobus_addr = A_CTRL;
    #1;
    check("arst_pre_intr", 32'(intr), 32'd1);
    check("arst_pre_ctrl", rd_data, 32'h100);
    rst_n = 1'b0;
    iobus_addr = A_LOAD;
    #1;
    check("arst_intr", 32'(intr), 32'd0);
    check("arst_load", rd_data, 32'd0);
    iobus_addr = A_CTRL;
    #1;
    check("arst_ctrl", rd_data, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      iobus_addr = A_COUNT;
      #1;
      check($sformatf("post_rst_intr_%0d", k), 32'(intr), 32'd0);
      check($sformatf("post_rst_count_%0d", k), rd_data, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
